mag_sqrt_iter: RTL
==================

// Module: mag_sqrt_iter
// PURPOSE
//  Sequential magnitude unit: y = sqrt(x1^2 + x2^2) for signed I/Q pairs, one result bit per clock.
//  Successor to the combinational magnitude block: parametrised width, optional round-to-nearest,
//  tag pass-through and valid/ready handshakes on both sides. Sits after the I/Q demodulator,
//  feeding the envelope path. No overlap of operations: throughput 1 result per DATA_IN_WIDTH+2 clocks.
// PARAMETERS
//  DATA_IN_WIDTH  16  width W of signed x1/x2 and of unsigned y (W >= 2)
//  ROUND          0   0 = floor(sqrt), 1 = round half-up to nearest integer
//  TAG_W          4   width of side-band tag carried from input to output (>= 1)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      x1/x2/in_tag valid
//  in_ready   out  1      block can accept; high only in IDLE
//  x1         in   W      signed first component
//  x2         in   W      signed second component
//  in_tag     in   TAG_W  side-band tag, returned with result
//  out_valid  out  1      y/out_tag valid; held until accepted
//  out_ready  in   1      downstream accepts result
//  y          out  W      unsigned magnitude
//  out_tag    out  TAG_W  tag captured at input handshake
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, y=0, out_tag=0, internal regs=0.
//  States: IDLE -> ITER -> DONE -> IDLE.
//  IDLE: in_ready=1. On edge with in_valid=1: sum <= x1*x1 + x2*x2 (2W-bit unsigned, full precision,
//   no overflow: max 2^(2W-1) at x1=x2=-2^(W-1)), tag latched, bit counter <= W-1, q=0, rem=0 -> ITER.
//  ITER: in_ready=0. Each edge: non-restoring/restoring digit recurrence, brings down next 2 MSBs of sum,
//   decides one root bit MSB-first (bit W-1 first). Counter decrements; after W iteration edges -> DONE.
//   On last iteration edge y is loaded: floor root q; if ROUND=1 and final remainder (sum - q^2) > q,
//   y = q+1 (cannot overflow W bits since sqrt(2^(2W-1)) < 2^W - 1).
//  DONE: out_valid=1, y/out_tag stable. Edge with out_ready=1 -> IDLE (out_valid=0, in_ready=1 next cycle).
//   out_ready low: hold indefinitely, y/out_tag unchanged, in_ready stays 0.
//  Latency: out_valid high in cycle W+1 after the accept cycle (accept edge + W iteration edges).
//  in_valid ignored outside IDLE; out_ready ignored outside DONE. y retains last result after handshake.
//  Same-cycle out accept + new in_valid: no bypass; new input accepted earliest 1 cycle after return to IDLE.
//  Result exact: y == floor(sqrt(sum)) (ROUND=0) for every input pair, incl. both at most-negative value.
// TESTING (W=16 unless noted)
//  1 Reset then (x1=3,x2=4,tag=5) -> y=5, out_tag=5, out_valid exactly 17 cycles after accept cycle.
//  2 ROUND=0/1: (-32768,-32768) -> 46340/46341; (2,3) -> 3/4; (1,1) -> 1/1; (0,0) -> 0/0.
//  3 Backpressure: out_ready low 10 cycles in DONE -> y, out_tag, out_valid=1 stable, in_ready=0;
//    then out_ready=1 -> out_valid=0 next cycle, in_ready=1, next input accepted.
//  4 Reset asserted mid-ITER (e.g. 5th iteration) -> outputs at reset values immediately, no stale
//    out_valid after release; fresh (6,-8) after release -> y=10.
//  5 in_valid toggled during ITER/DONE with other data -> ignored; result matches first accepted pair.
//  6 10k random signed pairs, random in_valid/out_ready, W=8 and W=16, both ROUND -> match model.

Source files
------------

// File: rtl/mag_sqrt_iter.sv
// mag_sqrt_iter: sequential magnitude y = sqrt(x1^2 + x2^2) for signed I/Q pairs.
// Restoring digit recurrence, one root bit per clock (MSB first), with optional
// round-half-up, a tag carried alongside the data, and valid/ready on both sides.
// Only one operation is in flight: IDLE -> ITER (W edges) -> DONE -> IDLE.
module mag_sqrt_iter #(
  parameter int DATA_IN_WIDTH = 16,
  parameter int ROUND         = 0,
  parameter int TAG_W         = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DATA_IN_WIDTH-1:0] x1,
  input  logic signed [DATA_IN_WIDTH-1:0] x2,
  input  logic [TAG_W-1:0]                in_tag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_IN_WIDTH-1:0]        y,
  output logic [TAG_W-1:0]                out_tag
);

  localparam int W  = DATA_IN_WIDTH;
  localparam int W2 = 2 * W;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t          r_state, w_state_nx;
  logic [W2-1:0]   r_sum;   // radicand, shifted left 2 bits per iteration
  logic [W-1:0]    r_q;     // partial root
  logic [W:0]      r_rem;   // partial remainder, never exceeds 2*q
  logic [CW-1:0]   r_cnt;   // iterations left minus one
  logic [W-1:0]    r_y;
  logic [TAG_W-1:0] r_tag;

  logic            w_in_ready, w_out_valid;
  logic            w_accept, w_last;

  // Squares of the signed inputs; full 2W precision, sum fits 2W unsigned.
  logic signed [W2-1:0] w_x1e, w_x2e, w_sq1, w_sq2;
  logic [W2-1:0]        w_sum;

  assign w_x1e = W2'(x1);
  assign w_x2e = W2'(x2);
  assign w_sq1 = w_x1e * w_x1e;
  assign w_sq2 = w_x2e * w_x2e;
  assign w_sum = w_sq1 + w_sq2;

  // One recurrence step: bring down the next 2 radicand bits, try 4q+1.
  logic [W+2:0] w_rem_sh, w_trial, w_diff;
  logic         w_ge;
  logic [W:0]   w_rem_nx;
  logic [W-1:0] w_q_nx, w_y_fin;
  logic         w_unused_hi;

  assign w_rem_sh    = {r_rem, r_sum[W2-1 -: 2]};
  assign w_trial     = {1'b0, r_q, 2'b01};
  assign w_ge        = (w_rem_sh >= w_trial);
  assign w_diff      = w_rem_sh - w_trial;
  assign w_rem_nx    = w_ge ? w_diff[W:0] : w_rem_sh[W:0];
  assign w_q_nx      = {r_q[W-2:0], w_ge};
  // Upper difference bits are zero whenever the trial subtraction is taken.
  assign w_unused_hi = ^w_diff[W+2:W+1];

  // Round half-up: remainder sum - q^2 greater than q means sqrt > q + 0.5.
  assign w_y_fin = ((ROUND != 0) && (w_rem_nx > {1'b0, w_q_nx})) ? (w_q_nx + W'(1)) : w_q_nx;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_ITER) && (r_cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nx  = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nx = S_ITER;
      end
      S_ITER: begin
        if (r_cnt == '0) w_state_nx = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in ITER, publish y on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_q   <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_y   <= '0;
      r_tag <= '0;
    end else if (w_accept) begin
      r_sum <= w_sum;
      r_q   <= '0;
      r_rem <= '0;
      r_cnt <= CW'(W - 1);
      r_tag <= in_tag;
    end else if (r_state == S_ITER) begin
      r_sum <= {r_sum[W2-3:0], 2'b00};
      r_q   <= w_q_nx;
      r_rem <= w_rem_nx;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) r_y <= w_y_fin;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign y         = r_y;
  assign out_tag   = r_tag;

endmodule
